// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects next-PC, drives the inst SRAM and
// hands {pc, inst} to decode, buffering the fetched word while decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst
);

  localparam int unsigned XLEN = 32;

  logic            fs_valid;
  logic [XLEN-1:0] fs_pc;
  logic            rd_fresh;
  logic            ibuf_valid;
  logic [XLEN-1:0] ibuf;

  logic            fs_allowin;
  logic [XLEN-1:0] nextpc;

  // Pre-IF next-PC selection; a redirect always forces the stage to accept.
  always_comb begin
    nextpc     = br_taken ? br_target : fs_pc + XLEN'(4);
    fs_allowin = !fs_valid || ds_allowin || br_taken;
  end

  assign inst_sram_en    = resetn && fs_allowin;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = '0;

  // A redirect squashes the wrong-path instruction currently presented.
  assign fs_to_ds_valid = fs_valid && !br_taken;
  assign fs_to_ds_pc    = fs_pc;
  assign fs_to_ds_inst  = ibuf_valid ? ibuf : inst_sram_rdata;

  // SRAM output is only trusted the cycle after an enabled read, so the first
  // stall cycle captures it into ibuf and later stall cycles keep the copy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid   <= 1'b0;
      fs_pc      <= RESET_PC - XLEN'(4);
      rd_fresh   <= 1'b0;
      ibuf_valid <= 1'b0;
      ibuf       <= '0;
    end else if (fs_allowin) begin
      fs_valid   <= 1'b1;
      fs_pc      <= nextpc;
      rd_fresh   <= 1'b1;
      ibuf_valid <= 1'b0;
    end else begin
      rd_fresh <= 1'b0;
      if (rd_fresh && !ibuf_valid) begin
        ibuf       <= inst_sram_rdata;
        ibuf_valid <= 1'b1;
      end
    end
  end

endmodule
